// File: rtl/cpu_b_pkg.sv
// rtl/cpu_b_pkg.sv - shared encodings and types for the 16-bit, 8-register CPU core
// Contents: opcode and ALU localparams, decoded-control bundle type and the
// imm6 sign-extension helper used by the decode stage.
package cpu_b_pkg;

  localparam int XLEN   = 16;
  localparam int REG_AW = 3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  // Control half of the ID/EX bundle; an all-zero value is a bubble.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic              wen;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              illegal;
  } dec_ctrl_t;

  function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
    return {{(XLEN-6){v[5]}}, v};
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [3:0] op);
    logic [3:0] alu;
    case (op)
      OP_SUB:  alu = ALU_SUB;
      OP_AND:  alu = ALU_AND;
      OP_OR:   alu = ALU_OR;
      OP_XOR:  alu = ALU_XOR;
      OP_SLL:  alu = ALU_SLL;
      OP_SRL:  alu = ALU_SRL;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - IF/regfile/EX signal bundle around the decode stage
// slave: the decode stage (takes IF handshake, regfile data, ex_ready; drives
//        if_ready, regfile read addresses and the ID/EX bundle).
// master: the surrounding pipeline.
// With ID_PERF_CNT_EN defined the bundle also carries stall_cnt / bubble_cnt.
interface id_stage_if #(parameter int PC_W = 16);
  import cpu_b_pkg::*;

  logic                  if_valid;
  logic                  if_ready;
  logic [XLEN-1:0]       if_inst;
  logic [PC_W-1:0]       if_pc;
  logic                  flush;
  logic [REG_AW-1:0]     rs1_addr_o;
  logic [REG_AW-1:0]     rs2_addr_o;
  logic [XLEN-1:0]       op1_i;
  logic [XLEN-1:0]       op2_i;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [PC_W-1:0]       ex_pc;
  logic [3:0]            ex_alu_op;
  logic [XLEN-1:0]       ex_op1;
  logic [XLEN-1:0]       ex_op2;
  logic [XLEN-1:0]       ex_imm;
  logic                  ex_use_imm;
  logic [REG_AW-1:0]     ex_rd;
  logic                  ex_wen;
  logic                  ex_mem_rd;
  logic                  ex_mem_wr;
  logic                  ex_branch;
  logic                  ex_illegal;
`ifdef ID_PERF_CNT_EN
  logic [15:0]           stall_cnt;
  logic [15:0]           bubble_cnt;
`endif

  modport slave (
    input  if_valid, if_inst, if_pc, flush, op1_i, op2_i, ex_ready,
    output if_ready, rs1_addr_o, rs2_addr_o, ex_valid, ex_pc, ex_alu_op,
           ex_op1, ex_op2, ex_imm, ex_use_imm, ex_rd, ex_wen, ex_mem_rd,
           ex_mem_wr, ex_branch, ex_illegal
`ifdef ID_PERF_CNT_EN
    , output stall_cnt, bubble_cnt
`endif
  );

  modport master (
    output if_valid, if_inst, if_pc, flush, op1_i, op2_i, ex_ready,
    input  if_ready, rs1_addr_o, rs2_addr_o, ex_valid, ex_pc, ex_alu_op,
           ex_op1, ex_op2, ex_imm, ex_use_imm, ex_rd, ex_wen, ex_mem_rd,
           ex_mem_wr, ex_branch, ex_illegal
`ifdef ID_PERF_CNT_EN
    , input stall_cnt, bubble_cnt
`endif
  );

endinterface

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational instruction decoder for the ID stage
// i_inst     : instruction word
// o_rs1/o_rs2: register-file read addresses
// o_rs1_used / o_rs2_used: whether the instruction actually reads that source
// o_ctrl     : decoded control (rd, alu_op, imm, use_imm, wen, mem, branch, illegal)
module id_decoder
  import cpu_b_pkg::*;
(
  input  logic [XLEN-1:0]   i_inst,
  output logic [REG_AW-1:0] o_rs1,
  output logic [REG_AW-1:0] o_rs2,
  output logic              o_rs1_used,
  output logic              o_rs2_used,
  output dec_ctrl_t         o_ctrl
);

  logic [3:0] w_opcode;
  assign w_opcode = i_inst[15:12];

  always_comb begin
    o_rs1          = i_inst[8:6];
    o_rs2          = i_inst[5:3];
    o_rs1_used     = 1'b1;
    o_rs2_used     = 1'b0;
    o_ctrl         = '0;
    o_ctrl.rd      = i_inst[11:9];
    o_ctrl.imm     = sext6(i_inst[5:0]);

    case (w_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        o_rs2_used    = 1'b1;
        o_ctrl.alu_op = rtype_alu(w_opcode);
        o_ctrl.wen    = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.use_imm = 1'b1;
        o_ctrl.wen     = 1'b1;
      end
      OP_LW: begin
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.use_imm = 1'b1;
        o_ctrl.wen     = 1'b1;
        o_ctrl.mem_rd  = 1'b1;
      end
      // SW and BEQ read their second source from the rd field.
      OP_SW: begin
        o_rs2          = i_inst[11:9];
        o_rs2_used     = 1'b1;
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.use_imm = 1'b1;
        o_ctrl.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        o_rs2          = i_inst[11:9];
        o_rs2_used     = 1'b1;
        o_ctrl.alu_op  = ALU_SUB;
        o_ctrl.branch  = 1'b1;
      end
      default: begin
        o_rs1_used     = 1'b0;
        o_ctrl.illegal = 1'b1;
      end
    endcase

    // r0 is hardwired, so a write to it is suppressed here rather than in EX.
    if (o_ctrl.rd == '0) o_ctrl.wen = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction-decode pipeline stage with load-use bubble and flush
// clk  : clock
// rst  : synchronous, active-low reset
// bus  : id_stage_if.slave (IF handshake, regfile read port, ID/EX bundle)
// Optional macro ID_PERF_CNT_EN adds saturating stall_cnt / bubble_cnt on bus.
module id_stage
  import cpu_b_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   bus
);

  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_rs1_used;
  logic              w_rs2_used;
  dec_ctrl_t         w_ctrl;

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  dec_ctrl_t         r_ctrl;

  logic              w_adv;
  logic              w_hz;
  logic              w_if_ready;
  logic              w_accept;

  id_decoder u_dec (
    .i_inst     (bus.if_inst),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used),
    .o_ctrl     (w_ctrl)
  );

  assign w_adv = !r_valid | bus.ex_ready;

  // A load in EX produces its result too late for the instruction behind it.
  assign w_hz = r_valid & r_ctrl.mem_rd & (r_ctrl.rd != '0) & bus.if_valid &
                ((w_rs1_used & (w_rs1 == r_ctrl.rd)) |
                 (w_rs2_used & (w_rs2 == r_ctrl.rd)));

  assign w_if_ready = rst & w_adv & !w_hz & !bus.flush;
  assign w_accept   = bus.if_valid & w_if_ready;

  // Any cycle where the bundle moves on without a replacement leaves an
  // all-zero bundle, so bubbles and flushed slots carry no control bits.
  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_ctrl  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= bus.if_pc;
      r_op1   <= bus.op1_i;
      r_op2   <= bus.op2_i;
      r_ctrl  <= w_ctrl;
    end else if (w_adv) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_ctrl  <= '0;
    end
  end

  assign bus.if_ready   = w_if_ready;
  assign bus.rs1_addr_o = w_rs1;
  assign bus.rs2_addr_o = w_rs2;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_pc      = r_pc;
  assign bus.ex_alu_op  = r_ctrl.alu_op;
  assign bus.ex_op1     = r_op1;
  assign bus.ex_op2     = r_op2;
  assign bus.ex_imm     = r_ctrl.imm;
  assign bus.ex_use_imm = r_ctrl.use_imm;
  assign bus.ex_rd      = r_ctrl.rd;
  assign bus.ex_wen     = r_ctrl.wen;
  assign bus.ex_mem_rd  = r_ctrl.mem_rd;
  assign bus.ex_mem_wr  = r_ctrl.mem_wr;
  assign bus.ex_branch  = r_ctrl.branch;
  assign bus.ex_illegal = r_ctrl.illegal;

`ifdef ID_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (bus.if_valid && !w_if_ready && !bus.flush && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_adv && w_hz && !bus.flush && r_bubble_cnt != 16'hFFFF)
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed, table-driven bench for id_stage
module tb_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.PC_W(16)) bus ();

  id_stage #(.PC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [3:0]  alu;
    logic [15:0] imm;
    logic        use_imm;
    logic        wen;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        illegal;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] inst, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic [2:0] rd,
                              input logic [3:0] alu, input logic [15:0] imm,
                              input logic [5:0] flags);
    vec_t v;
    v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.alu = alu; v.imm = imm;
    {v.use_imm, v.wen, v.mem_rd, v.mem_wr, v.branch, v.illegal} = flags;
    v.pc = 16'h0; v.op1 = 16'h0; v.op2 = 16'h0;
    return v;
  endfunction

  task automatic drive(input logic valid, input logic [15:0] inst, input logic [15:0] pc,
                       input logic [15:0] op1, input logic [15:0] op2);
    bus.if_valid = valid;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    bus.op1_i    = op1;
    bus.op2_i    = op2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
  endtask

  initial begin
    // flags: {use_imm, wen, mem_rd, mem_wr, branch, illegal}
    vecs[0]  = mk(16'h72BD, 3'd2, 3'd7, 3'd1, 4'd0, 16'hFFFD, 6'b110000); // ADDI r1,r2,-3
    vecs[1]  = mk(16'h7283, 3'd2, 3'd0, 3'd1, 4'd0, 16'h0003, 6'b110000); // ADDI r1,r2,3
    vecs[2]  = mk(16'h08D0, 3'd3, 3'd2, 3'd4, 4'd0, 16'h0010, 6'b010000); // ADD r4,r3,r2
    vecs[3]  = mk(16'h1050, 3'd1, 3'd2, 3'd0, 4'd1, 16'h0010, 6'b000000); // SUB r0 -> no wen
    vecs[4]  = mk(16'h2248, 3'd1, 3'd1, 3'd1, 4'd2, 16'h0008, 6'b010000); // AND
    vecs[5]  = mk(16'h3D60, 3'd5, 3'd4, 3'd6, 4'd3, 16'hFFE0, 6'b010000); // OR
    vecs[6]  = mk(16'h4490, 3'd2, 3'd2, 3'd2, 4'd4, 16'h0010, 6'b010000); // XOR
    vecs[7]  = mk(16'h5FA8, 3'd6, 3'd5, 3'd7, 4'd5, 16'hFFE8, 6'b010000); // SLL
    vecs[8]  = mk(16'h6239, 3'd0, 3'd7, 3'd1, 4'd6, 16'hFFF9, 6'b010000); // SRL
    vecs[9]  = mk(16'h8640, 3'd1, 3'd0, 3'd3, 4'd0, 16'h0000, 6'b111000); // LW r3,0(r1)
    vecs[10] = mk(16'h9040, 3'd1, 3'd0, 3'd0, 4'd0, 16'h0000, 6'b100100); // SW r0
    vecs[11] = mk(16'h9A7F, 3'd1, 3'd5, 3'd5, 4'd0, 16'hFFFF, 6'b100100); // SW r5,-1(r1)
    vecs[12] = mk(16'hA705, 3'd4, 3'd3, 3'd3, 4'd1, 16'h0005, 6'b000010); // BEQ r4,r3
    vecs[13] = mk(16'hC000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0000, 6'b000001); // illegal
    vecs[14] = mk(16'hFFFF, 3'd7, 3'd7, 3'd7, 4'd0, 16'hFFFF, 6'b000001); // illegal
    vecs[15] = mk(16'h0800, 3'd0, 3'd0, 3'd4, 4'd0, 16'h0000, 6'b010000); // ADD r4,r0,r0
    vecs[16] = mk(16'h7041, 3'd1, 3'd0, 3'd0, 4'd0, 16'h0001, 6'b100000); // ADDI r0 -> no wen
    for (int i = 0; i < 17; i++) begin
      vecs[i].pc  = 16'h0100 + 16'(i * 2);
      vecs[i].op1 = 16'h1000 + 16'(i);
      vecs[i].op2 = 16'h2000 + 16'(i);
    end
    vecs[0].op1 = 16'h0010;

    // Reset with IF presenting an instruction
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    drive(1'b1, 16'h08D0, 16'h0042, 16'hBEEF, 16'hCAFE);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
      chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_ex_data", 32'(bus.ex_pc | bus.ex_op1 | bus.ex_op2 | bus.ex_imm), 32'd0);
      chk("rst_ex_ctrl", 32'({bus.ex_alu_op, bus.ex_use_imm, bus.ex_rd, bus.ex_wen,
                              bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_branch, bus.ex_illegal}), 32'd0);
    end
    rst = 1'b1;
    idle();

    // Decode table
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].op1, vecs[i].op2);
      #1;
      chk($sformatf("v%0d_rs1_addr", i), 32'(bus.rs1_addr_o), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2_addr", i), 32'(bus.rs2_addr_o), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_if_ready", i), 32'(bus.if_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 32'd1);
      chk($sformatf("v%0d_ex_pc", i), 32'(bus.ex_pc), 32'(vecs[i].pc));
      chk($sformatf("v%0d_ex_op1", i), 32'(bus.ex_op1), 32'(vecs[i].op1));
      chk($sformatf("v%0d_ex_op2", i), 32'(bus.ex_op2), 32'(vecs[i].op2));
      chk($sformatf("v%0d_ex_imm", i), 32'(bus.ex_imm), 32'(vecs[i].imm));
      chk($sformatf("v%0d_ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_ex_alu_op", i), 32'(bus.ex_alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_ex_flags", i),
          32'({bus.ex_use_imm, bus.ex_wen, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_branch, bus.ex_illegal}),
          32'({vecs[i].use_imm, vecs[i].wen, vecs[i].mem_rd, vecs[i].mem_wr, vecs[i].branch, vecs[i].illegal}));
      idle();
      chk($sformatf("v%0d_drain", i), 32'(bus.ex_valid), 32'd0);
    end

    // Load-use: LW r3 then ADD r4,r3,r2 -> one bubble
    drive(1'b1, 16'h8640, 16'h0200, 16'h0001, 16'h0002);
    tick();
    chk("lu_lw_valid", 32'(bus.ex_valid), 32'd1);
    drive(1'b1, 16'h08D0, 16'h0202, 16'h3333, 16'h4444);
    #1;
    chk("lu_stall_if_ready", 32'(bus.if_ready), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_bubble_ctrl", 32'({bus.ex_wen, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_branch, bus.ex_illegal}), 32'd0);
    chk("lu_resume_if_ready", 32'(bus.if_ready), 32'd1);
    tick();
    chk("lu_add_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_add_rd", 32'(bus.ex_rd), 32'd4);
    chk("lu_add_op1", 32'(bus.ex_op1), 32'h3333);
    idle();

    // Load-use through the store-data source: LW r3 then SW r3
    drive(1'b1, 16'h8640, 16'h0210, 16'h0, 16'h0);
    tick();
    drive(1'b1, 16'h9640, 16'h0212, 16'h0, 16'h0);
    #1;
    chk("lu_sw_if_ready", 32'(bus.if_ready), 32'd0);
    idle();
    idle();

    // Load to r0 never stalls
    drive(1'b1, 16'h8040, 16'h0220, 16'h0, 16'h0);
    tick();
    drive(1'b1, 16'h0800, 16'h0222, 16'h0, 16'h0);
    #1;
    chk("lu_r0_if_ready", 32'(bus.if_ready), 32'd1);
    idle();
    idle();

    // Backpressure: hold bundle for 4 cycles
    bus.ex_ready = 1'b0;
    drive(1'b1, 16'h08D0, 16'h0040, 16'hAAAA, 16'h5555);
    #1;
    chk("bp_first_if_ready", 32'(bus.if_ready), 32'd1);
    tick();
    chk("bp_first_valid", 32'(bus.ex_valid), 32'd1);
    drive(1'b1, 16'h2248, 16'h0042, 16'h1111, 16'h2222);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp%0d_if_ready", c), 32'(bus.if_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_hold", c),
          32'({bus.ex_valid, bus.ex_rd, bus.ex_wen}), 32'({1'b1, 3'd4, 1'b1}));
      chk($sformatf("bp%0d_hold_data", c), 32'({bus.ex_op1, bus.ex_pc}), 32'hAAAA_0040);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("bp_release_if_ready", 32'(bus.if_ready), 32'd1);
    tick();
    chk("bp_next_valid", 32'(bus.ex_valid), 32'd1);
    chk("bp_next_rd", 32'(bus.ex_rd), 32'd1);
    chk("bp_next_data", 32'({bus.ex_op1, bus.ex_pc}), 32'h1111_0042);
    idle();

    // Flush while EX stalls and IF offers an instruction
    bus.ex_ready = 1'b0;
    drive(1'b1, 16'h08D0, 16'h0060, 16'h0, 16'h0);
    tick();
    chk("fl_pre_valid", 32'(bus.ex_valid), 32'd1);
    drive(1'b1, 16'h2248, 16'h0062, 16'h0, 16'h0);
    bus.flush = 1'b1;
    #1;
    chk("fl_if_ready", 32'(bus.if_ready), 32'd0);
    tick();
    chk("fl_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl_rd", 32'(bus.ex_rd), 32'd0);
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    chk("fl_not_issued", 32'(bus.ex_valid), 32'd0);
    idle();

    // Flush during a load-use hazard clears the hazard
    drive(1'b1, 16'h8640, 16'h0080, 16'h0, 16'h0);
    tick();
    drive(1'b1, 16'h08D0, 16'h0082, 16'h7777, 16'h0);
    bus.flush = 1'b1;
    tick();
    chk("flhz_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;
    #1;
    chk("flhz_if_ready", 32'(bus.if_ready), 32'd1);
    tick();
    chk("flhz_issue", 32'({bus.ex_valid, bus.ex_rd}), 32'({1'b1, 3'd4}));
    chk("flhz_op1", 32'(bus.ex_op1), 32'h7777);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
